// File: rtl/key_matrix_mapped_if.sv
// Keyboard event and map-table write port shared by the host and key_matrix_mapped.
// MAPW must equal 2 + clog2(NCOLS) + clog2(NROWS) of the attached matrix.
interface key_matrix_mapped_if #(
  parameter int unsigned MAPW = 8
) ();
  logic            key_strobe;
  logic            key_pressed;
  logic            key_extended;
  logic [7:0]      key_code;
  logic            map_we;
  logic [8:0]      map_addr;
  logic [MAPW-1:0] map_data;

  modport master (
    output key_strobe, key_pressed, key_extended, key_code,
    output map_we, map_addr, map_data
  );

  modport slave (
    input key_strobe, key_pressed, key_extended, key_code,
    input map_we, map_addr, map_data
  );
endinterface

// File: rtl/key_matrix_mapped.sv
// Scan-code to key-matrix mapper: programmable 512-entry map, three-stage event
// pipeline, scanned row output, pressed-key count and held soft reset / NMI requests.
module key_matrix_mapped #(
  parameter int unsigned NCOLS    = 8,
  parameter int unsigned NROWS    = 8,
  parameter int unsigned HOLD_MIN = 16,
  localparam int unsigned COLW    = $clog2(NCOLS),
  localparam int unsigned RW      = $clog2(NROWS)
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  key_matrix_mapped_if.slave     kbd,
  input  logic                   clear_all,
  input  logic [COLW-1:0]        col,
  input  logic [NROWS-1:0]       row_mask,
  output logic [NROWS-1:0]       row_out,
  output logic [7:0]             key_count,
  output logic                   swrst,
  output logic                   swnmi
);
  localparam int unsigned MAPW = 2 + COLW + RW;
  localparam int unsigned HW   = $clog2(HOLD_MIN + 1);

  localparam logic [1:0] KIND_NONE   = 2'b00;
  localparam logic [1:0] KIND_MATRIX = 2'b01;
  localparam logic [1:0] KIND_RESET  = 2'b10;
  localparam logic [1:0] KIND_NMI    = 2'b11;

  logic [MAPW-1:0] map_mem [512];

  logic            s0_valid, s0_pressed;
  logic [8:0]      s0_addr;
  logic            s1_valid, s1_pressed;
  logic [MAPW-1:0] s1_entry;
  logic            s2_valid, s2_pressed;
  logic [MAPW-1:0] s2_entry;

  logic [1:0]      s2_kind;
  logic [COLW-1:0] s2_col;
  logic [RW-1:0]   s2_row;

  logic [NCOLS-1:0][NROWS-1:0] matrix, matrix_nxt;
  logic [7:0]      key_count_nxt;
  logic            rst_held, rst_held_nxt, nmi_held, nmi_held_nxt;
  logic [HW-1:0]   rst_cnt, rst_cnt_nxt, nmi_cnt, nmi_cnt_nxt;
  logic [NROWS-1:0] row_sel;

  assign {s2_kind, s2_col, s2_row} = s2_entry;

  // Map table keeps its contents across reset; a same-edge write is not seen by the read.
  always_ff @(posedge clk_sys) begin
    if (kbd.map_we) map_mem[kbd.map_addr] <= kbd.map_data;
    s1_entry <= map_mem[s0_addr];
  end

  // Event pipeline: S0 capture, S1 table read, S2 entry held for apply.
  always_ff @(posedge clk_sys) begin
    if (!reset_n || clear_all) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s0_valid <= kbd.key_strobe;
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
    end
    s0_addr    <= {kbd.key_extended, kbd.key_code};
    s0_pressed <= kbd.key_pressed;
    s1_pressed <= s0_pressed;
    s2_pressed <= s1_pressed;
    s2_entry   <= s1_entry;
  end

  // Apply the S2 event; out-of-range col/row never match a matrix cell.
  always_comb begin
    matrix_nxt    = matrix;
    key_count_nxt = key_count;
    rst_held_nxt  = rst_held;
    nmi_held_nxt  = nmi_held;
    rst_cnt_nxt   = (rst_cnt != '0) ? rst_cnt - HW'(1) : rst_cnt;
    nmi_cnt_nxt   = (nmi_cnt != '0) ? nmi_cnt - HW'(1) : nmi_cnt;
    if (s2_valid) begin
      case (s2_kind)
        KIND_NONE: ;
        KIND_MATRIX: begin
          for (int c = 0; c < int'(NCOLS); c++) begin
            for (int r = 0; r < int'(NROWS); r++) begin
              if (s2_col == COLW'(c) && s2_row == RW'(r) && matrix[c][r] != s2_pressed) begin
                matrix_nxt[c][r] = s2_pressed;
                if (s2_pressed && key_count != 8'hFF)
                  key_count_nxt = key_count + 8'd1;
                else if (!s2_pressed && key_count != 8'h00)
                  key_count_nxt = key_count - 8'd1;
              end
            end
          end
        end
        KIND_RESET: begin
          rst_held_nxt = s2_pressed;
          if (s2_pressed) rst_cnt_nxt = HW'(HOLD_MIN);
        end
        KIND_NMI: begin
          nmi_held_nxt = s2_pressed;
          if (s2_pressed) nmi_cnt_nxt = HW'(HOLD_MIN);
        end
        default: ;
      endcase
    end
    if (clear_all) begin
      matrix_nxt    = '0;
      key_count_nxt = '0;
      rst_held_nxt  = 1'b0;
      nmi_held_nxt  = 1'b0;
      rst_cnt_nxt   = '0;
      nmi_cnt_nxt   = '0;
    end
  end

  always_comb begin
    row_sel = '0;
    for (int c = 0; c < int'(NCOLS); c++) begin
      if (col == COLW'(c)) row_sel = matrix[c];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      matrix    <= '0;
      key_count <= '0;
      rst_held  <= 1'b0;
      nmi_held  <= 1'b0;
      rst_cnt   <= '0;
      nmi_cnt   <= '0;
      swrst     <= 1'b0;
      swnmi     <= 1'b0;
      row_out   <= '0;
    end else begin
      matrix    <= matrix_nxt;
      key_count <= key_count_nxt;
      rst_held  <= rst_held_nxt;
      nmi_held  <= nmi_held_nxt;
      rst_cnt   <= rst_cnt_nxt;
      nmi_cnt   <= nmi_cnt_nxt;
      swrst     <= rst_held_nxt | (rst_cnt_nxt != '0);
      swnmi     <= nmi_held_nxt | (nmi_cnt_nxt != '0);
      row_out   <= row_sel & row_mask;
    end
  end
endmodule
